float_subtractor_seq: RTL and testbench

Multi-cycle IEEE-754 single-precision subtractor that computes diff = a - b. It is the inverse-operation companion to the combinational float adder in the same datapath. Subtraction is done by flipping b's sign and running a one-bit-per-cycle align/normalise FSM. This keeps area small and adds the leading-zero normalisation that cancellation requires.

---
 rtl/float_subtractor_seq.sv | 205 ++++++++++++++++++++
 tb/tb_float_subtractor_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/float_subtractor_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (diff = a - b).
// One-bit-per-cycle alignment and normalisation keep the datapath to a single adder.
module float_subtractor_seq #(
    parameter int MAX_ALIGN = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] diff
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t      state, state_next;
    logic        done_next;
    logic [31:0] diff_next;

    logic        sx, sy, sign;
    logic [7:0]  e, d;
    logic [23:0] mx, my;
    logic [24:0] r;

    logic        sx_next, sy_next, sign_next;
    logic [7:0]  e_next, d_next;
    logic [23:0] mx_next, my_next;
    logic [24:0] r_next;

    // Capture-side decode of the operands (b sign flipped, denormals flushed)
    logic [7:0]  cap_ea, cap_eb, cap_ex, cap_ey, cap_d;
    logic [23:0] cap_ma, cap_mb, cap_mx, cap_my;
    logic        cap_sa, cap_sb, cap_sx, cap_sy, cap_swap, cap_special;

    // Adder results for the ADD state
    logic [24:0] add_r;
    logic        add_sign;

    // Carry-out normalisation, saturating to infinity when the exponent overflows.
    function automatic logic [31:0] pack_carry(input logic s, input logic [7:0] ex,
                                               input logic [24:0] rr);
        logic [7:0] ex_inc;
        ex_inc = ex + 8'd1;
        if (ex_inc == 8'hFF)
            pack_carry = {s, 8'hFF, 23'h0};
        else
            pack_carry = {s, ex_inc, rr[23:1]};
    endfunction

    assign busy = (state != IDLE);

    always_comb begin
        cap_ea      = a[30:23];
        cap_eb      = b[30:23];
        cap_sa      = a[31];
        cap_sb      = ~b[31];
        cap_ma      = (cap_ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
        cap_mb      = (cap_eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
        cap_swap    = (cap_eb > cap_ea);
        cap_ex      = cap_swap ? cap_eb : cap_ea;
        cap_ey      = cap_swap ? cap_ea : cap_eb;
        cap_sx      = cap_swap ? cap_sb : cap_sa;
        cap_sy      = cap_swap ? cap_sa : cap_sb;
        cap_mx      = cap_swap ? cap_mb : cap_ma;
        cap_my      = cap_swap ? cap_ma : cap_mb;
        cap_d       = cap_ex - cap_ey;
        cap_special = (cap_ea == 8'hFF) || (cap_eb == 8'hFF);
        if (int'(cap_d) >= MAX_ALIGN) begin
            cap_my = 24'd0;
            cap_d  = 8'd0;
        end
    end

    always_comb begin
        add_r    = 25'd0;
        add_sign = sx;
        if (sx == sy) begin
            add_r    = {1'b0, mx} + {1'b0, my};
            add_sign = sx;
        end else if (mx >= my) begin
            add_r    = {1'b0, mx} - {1'b0, my};
            add_sign = sx;
        end else begin
            add_r    = {1'b0, my} - {1'b0, mx};
            add_sign = sy;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        diff_next  = diff;
        sx_next    = sx;
        sy_next    = sy;
        sign_next  = sign;
        e_next     = e;
        d_next     = d;
        mx_next    = mx;
        my_next    = my;
        r_next     = r;

        case (state)
            IDLE: begin
                if (start) begin
                    sx_next = cap_sx;
                    sy_next = cap_sy;
                    e_next  = cap_ex;
                    d_next  = cap_d;
                    mx_next = cap_mx;
                    my_next = cap_my;
                    if (cap_special) begin
                        diff_next  = 32'h7FC00000;
                        done_next  = 1'b1;
                        state_next = DONE;
                    end else if (cap_d != 8'd0) begin
                        state_next = ALIGN;
                    end else begin
                        state_next = ADD;
                    end
                end
            end

            ALIGN: begin
                my_next = my >> 1;
                d_next  = d - 8'd1;
                if (d == 8'd1)
                    state_next = ADD;
            end

            ADD: begin
                r_next    = add_r;
                sign_next = add_sign;
                if (add_r == 25'd0) begin
                    diff_next  = 32'h00000000;
                    done_next  = 1'b1;
                    state_next = DONE;
                end else begin
                    state_next = NORM;
                end
            end

            NORM: begin
                if (r[24]) begin
                    r_next     = r >> 1;
                    e_next     = e + 8'd1;
                    diff_next  = pack_carry(sign, e, r);
                    done_next  = 1'b1;
                    state_next = DONE;
                end else if (r[23]) begin
                    diff_next  = {sign, e, r[22:0]};
                    done_next  = 1'b1;
                    state_next = DONE;
                end else if (e > 8'd1) begin
                    r_next = r << 1;
                    e_next = e - 8'd1;
                    // Finish on the shift that brings the hidden bit into place
                    if (r[22]) begin
                        diff_next  = {sign, e - 8'd1, r[21:0], 1'b0};
                        done_next  = 1'b1;
                        state_next = DONE;
                    end
                end else begin
                    diff_next  = 32'h00000000;
                    done_next  = 1'b1;
                    state_next = DONE;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            diff  <= 32'h0;
        end else begin
            state <= state_next;
            done  <= done_next;
            diff  <= diff_next;
        end
    end

    // Datapath working registers carry no reset; they are always loaded at capture.
    always_ff @(posedge clk) begin
        sx   <= sx_next;
        sy   <= sy_next;
        sign <= sign_next;
        e    <= e_next;
        d    <= d_next;
        mx   <= mx_next;
        my   <= my_next;
        r    <= r_next;
    end

endmodule

// File: tb/tb_float_subtractor_seq.sv
// Directed bench for float_subtractor_seq: results, latency, busy/done handshake,
// start-while-busy immunity and asynchronous reset mid-operation.
module tb_float_subtractor_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] diff;

    int tests_run;
    int tests_failed;

    float_subtractor_seq #(.MAX_ALIGN(25)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .diff (diff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One operation: pulse start for one cycle, then measure k and busy cycles.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_in,
                          input logic [31:0] exp_diff, input int exp_k);
        int k;
        int busy_cnt;
        @(negedge clk);
        a = ta;
        b = tb_in;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && k < 100) begin
            @(posedge clk);
            #1;
            k++;
            if (busy) busy_cnt++;
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " diff"}, diff, exp_diff);
        check({tag, " k"}, 32'(k), 32'(exp_k));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_k));
        @(posedge clk);
        #1;
        check({tag, " done_drop"}, 32'(done), 32'd0);
        check({tag, " idle"}, 32'(busy), 32'd0);
        check({tag, " diff_hold"}, diff, exp_diff);
    endtask

    initial begin
        int k;
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = 32'h0;
        b     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset diff", diff, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post-reset idle", 32'(busy), 32'd0);

        run_op("3-1",        32'h40400000, 32'h3F800000, 32'h40000000, 4);
        run_op("1-0.75",     32'h3F800000, 32'h3F400000, 32'h3E800000, 5);
        run_op("1-3",        32'h3F800000, 32'h40400000, 32'hC0000000, 4);
        run_op("1.5+1.5",    32'h3FC00000, 32'hBFC00000, 32'h40400000, 3);
        run_op("pi-pi",      32'h40490FDB, 32'h40490FDB, 32'h00000000, 2);
        run_op("d25",        32'h3F800000, 32'h33000000, 32'h3F800000, 3);
        run_op("inf",        32'h7F800000, 32'h3F800000, 32'h7FC00000, 1);
        run_op("1-2^-11",    32'h3F800000, 32'h3A000000, 32'h3F7FE000, 14);
        run_op("denorm",     32'h00400000, 32'h00000000, 32'h00000000, 2);

        // start held high and operands scrambled while busy
        @(negedge clk);
        a = 32'h40400000;
        b = 32'h3F800000;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 32'h7F800000;
        b = 32'h12345678;
        k = 1;
        while (!done && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("busy-start diff", diff, 32'h40000000);
        check("busy-start k", 32'(k), 32'd4);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start-in-done ignored", 32'(busy), 32'd0);
        check("start-in-done no done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("no second done", 32'(done), 32'd0);
        check("no second op", 32'(busy), 32'd0);

        // async reset while in ALIGN (d=11)
        @(negedge clk);
        a = 32'h3F800000;
        b = 32'h3A000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("mid-align busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst done", 32'(done), 32'd0);
        check("async rst diff", diff, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after rst 3-1", 32'h40400000, 32'h3F800000, 32'h40000000, 4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
